// File: rtl/aes_key_expand.sv
// aes_key_expand: AES-128 key schedule that fetches SubWord bytes over the shared S-box handshake and stores rk0..rk10
module aes_key_expand (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [127:0] cipher_key,
  input  logic [3:0]   rk_idx,
  output logic [127:0] round_key,
  output logic         busy,
  output logic         done,
  output logic         key_valid,
  output logic [7:0]   sbox_rqst_addr,
  output logic         flag_address_sent,
  input  logic         flag_data_sent,
  input  logic [7:0]   sbox_read_data
);
  typedef enum logic [2:0] {IDLE, LOAD, SUB, XOR, DONE} state_t;
  localparam logic [7:0] RCON [0:9] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};
  state_t state, state_n;
  logic [3:0] r;
  logic [1:0] b;
  logic [127:0] cur;
  logic [127:0] rk [0:10];
  logic [31:0] sub, t, w4, w5, w6, w7;
  logic [7:0] rcon;
  logic ack;
  function automatic logic [7:0] rot_byte(input logic [31:0] w, input logic [1:0] i);
    return i == 2'd0 ? w[23:16] : i == 2'd1 ? w[15:8] : i == 2'd2 ? w[7:0] : w[31:24];
  endfunction
  assign ack = flag_address_sent & flag_data_sent;
  assign busy = state == LOAD || state == SUB || state == XOR;
  assign done = state == DONE;
  assign rcon = (r != 4'd0 && r <= 4'd10) ? RCON[r - 4'd1] : 8'h00;
  assign t = sub ^ {rcon, 24'h0};
  assign w4 = cur[127:96] ^ t;
  assign w5 = cur[95:64] ^ w4;
  assign w6 = cur[63:32] ^ w5;
  assign w7 = cur[31:0] ^ w6;
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_n;
  always_comb begin
    state_n = (state == IDLE || state == DONE) ? (start ? LOAD : IDLE) :
              state == LOAD ? SUB :
              state == SUB  ? ((ack && b == 2'd3) ? XOR : SUB) :
              state == XOR  ? (r == 4'd10 ? DONE : SUB) : IDLE;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r <= '0;
      b <= '0;
      cur <= '0;
      sub <= '0;
      round_key <= '0;
      key_valid <= 1'b0;
      sbox_rqst_addr <= '0;
      flag_address_sent <= 1'b0;
      for (int i = 0; i < 11; i++) rk[i] <= '0;
    end else begin
      round_key <= rk_idx <= 4'd10 ? rk[rk_idx] : '0;
      if ((state == IDLE || state == DONE) && start) begin
        cur <= cipher_key;
        key_valid <= 1'b0;
      end else if (state == LOAD) begin
        rk[0] <= cur;
        r <= 4'd1;
        b <= 2'd0;
        flag_address_sent <= 1'b1;
        sbox_rqst_addr <= rot_byte(cur[31:0], 2'd0);
      end else if (state == SUB) begin
        // request low after each capture gives the mandatory one-cycle gap
        if (ack) begin
          sub <= {sub[23:0], sbox_read_data};
          flag_address_sent <= 1'b0;
          b <= b + 2'd1;
        end else if (!flag_address_sent) begin
          flag_address_sent <= 1'b1;
          sbox_rqst_addr <= rot_byte(cur[31:0], b);
        end
      end else if (state == XOR) begin
        cur <= {w4, w5, w6, w7};
        rk[r] <= {w4, w5, w6, w7};
        if (r != 4'd10) begin
          r <= r + 4'd1;
          flag_address_sent <= 1'b1;
          sbox_rqst_addr <= rot_byte(w7, 2'd0);
        end else key_valid <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_aes_key_expand.sv
// tb_aes_key_expand: directed bench with a word-level key-schedule model and an S-box responder of programmable latency
module tb_aes_key_expand;
  logic clk = 0, rst, start, flag_data_sent, spur;
  logic [127:0] cipher_key, round_key;
  logic [3:0] rk_idx;
  logic busy, done, key_valid, flag_address_sent;
  logic [7:0] sbox_rqst_addr, sbox_read_data;
  int total = 0, bad = 0, lat = 1, cnt;
  logic [7:0] sb [256];
  logic [127:0] exp [16];
  logic [127:0] rows [16] = '{
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};
  localparam logic [127:0] FIPS = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] K3 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] K4 = 128'hfedcba9876543210f0e1d2c3b4a59687;

  aes_key_expand dut (
    .clk(clk), .rst(rst), .start(start), .cipher_key(cipher_key), .rk_idx(rk_idx),
    .round_key(round_key), .busy(busy), .done(done), .key_valid(key_valid),
    .sbox_rqst_addr(sbox_rqst_addr), .flag_address_sent(flag_address_sent),
    .flag_data_sent(flag_data_sent), .sbox_read_data(sbox_read_data));

  always #5 clk = ~clk;

  always @(posedge clk or posedge rst)
    if (rst) cnt <= 0;
    else cnt <= flag_address_sent ? cnt + 1 : 0;
  assign flag_data_sent = (flag_address_sent && cnt == lat - 1) || (spur && !flag_address_sent);
  assign sbox_read_data = flag_address_sent ? sb[sbox_rqst_addr] : 8'h5a;

  task automatic chk(input string n, input logic [127:0] a, input logic [127:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", n, a, e, $time);
    end
  endtask

  function automatic void expand(input logic [127:0] k);
    logic [31:0] w [44];
    logic [31:0] tw;
    logic [7:0] rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      tw = w[i-1];
      if (i % 4 == 0) begin
        tw = {sb[tw[23:16]], sb[tw[15:8]], sb[tw[7:0]], sb[tw[31:24]]} ^ {rc, 24'h0};
        rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
      end
      w[i] = w[i-4] ^ tw;
    end
    for (int r = 0; r < 16; r++) exp[r] = r <= 10 ? {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]} : '0;
  endfunction

  logic p_req, p_ack, p_kv;
  logic [7:0] p_addr;
  logic [3:0] p_idx;
  always @(posedge clk or posedge rst)
    if (rst) {p_req, p_ack, p_kv, p_addr, p_idx} <= '0;
    else {p_req, p_ack, p_kv, p_addr, p_idx} <= {flag_address_sent, flag_data_sent, key_valid, sbox_rqst_addr, rk_idx};

  always @(negedge clk)
    if (!rst) begin
      if (p_kv && key_valid) chk("read", round_key, exp[p_idx]);
      if (p_req && !p_ack) begin
        chk("hold_req", flag_address_sent, 1);
        chk("hold_addr", sbox_rqst_addr, p_addr);
      end
      if (p_req && p_ack) chk("gap", flag_address_sent, 0);
      if (!busy) chk("idle_req", flag_address_sent, 0);
    end

  task automatic run(input logic [127:0] k, input int l, input int inj);
    int n = 0;
    lat = l;
    start = 1;
    cipher_key = k;
    @(posedge clk);
    #1 start = 0;
    cipher_key = ~k;
    expand(k);
    chk("busy_e0", busy, 1);
    chk("kv_clr", key_valid, 0);
    while (!done && n < 400) begin
      @(posedge clk);
      #1 n++;
      start = n == inj;
      if (n == inj) cipher_key = K4;
    end
    start = 0;
    chk("latency", n, 1 + 10*(4*l + 4));
    chk("kv_done", key_valid, 1);
    chk("busy_done", busy, 0);
  endtask

  task automatic rd(input logic [3:0] i, output logic [127:0] v);
    @(negedge clk);
    rk_idx = i;
    @(negedge clk);
    v = round_key;
  endtask

  task automatic done_pulse();
    @(posedge clk);
    #1 chk("done_pulse", done, 0);
    chk("kv_hold", key_valid, 1);
  endtask

  initial begin
    logic [127:0] v;
    int n;
    for (int i = 0; i < 16; i++)
      for (int j = 0; j < 16; j++) sb[16*i+j] = rows[i][127 - 8*j -: 8];
    for (int i = 0; i < 16; i++) exp[i] = '0;
    rst = 1; start = 0; cipher_key = '0; rk_idx = '0; spur = 0;
    repeat (2) @(negedge clk);
    chk("rst_rk", round_key, 0);
    chk("rst_ctl", {busy, done, key_valid, sbox_rqst_addr, flag_address_sent}, 0);
    rst = 0;
    @(negedge clk);
    run(FIPS, 1, 0);
    chk("model_fips_rk1", exp[1], 128'ha0fafe1788542cb123a339392a6c7605);
    chk("model_fips_rk10", exp[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    done_pulse();
    for (int i = 0; i < 16; i++) begin
      rd(i[3:0], v);
      chk("sweep", v, i == 0 ? FIPS : i == 1 ? 128'ha0fafe1788542cb123a339392a6c7605 :
                      i == 10 ? 128'hd014f9a8c9ee2589e13f0cc8b6630ca6 : exp[i]);
    end
    @(negedge clk);
    run('0, 3, 0);
    chk("model_zero_rk1", exp[1], 128'h62636363626363636263636362636363);
    chk("model_zero_rk10", exp[10], 128'hb4ef5bcb3e92e21123e951cf6f8f188e);
    done_pulse();
    rd(4'd1, v);
    chk("zero_rk1", v, 128'h62636363626363636263636362636363);
    rd(4'd10, v);
    chk("zero_rk10", v, 128'hb4ef5bcb3e92e21123e951cf6f8f188e);
    @(negedge clk);
    run(FIPS, 1, 20);
    done_pulse();
    rd(4'd10, v);
    chk("busy_start_rk10", v, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    rd(4'd1, v);
    chk("busy_start_rk1", v, 128'ha0fafe1788542cb123a339392a6c7605);
    @(negedge clk);
    run('0, 1, 0);
    chk("in_done", done, 1);
    run(K3, 2, 0);
    chk("model_k3_rk10", exp[10], 128'h13111d7fe3944a17f307a78b4d2b30c5);
    done_pulse();
    rd(4'd10, v);
    chk("k3_rk10", v, 128'h13111d7fe3944a17f307a78b4d2b30c5);
    @(negedge clk);
    lat = 2;
    start = 1;
    cipher_key = K4;
    @(posedge clk);
    #1 start = 0;
    repeat (49) @(posedge clk);
    n = 0;
    @(negedge clk);
    while (!flag_address_sent && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("r5_req", flag_address_sent, 1);
    #2 rst = 1;
    #1 chk("async_rk", round_key, 0);
    chk("async_ctl", {busy, done, key_valid, sbox_rqst_addr, flag_address_sent}, 0);
    @(negedge clk);
    rst = 0;
    @(negedge clk);
    run(K4, 2, 0);
    done_pulse();
    for (int i = 1; i <= 10; i++) begin
      rd(i[3:0], v);
      chk("post_rst", v, exp[i]);
    end
    spur = 1;
    repeat (5) @(negedge clk);
    chk("spur_idle", {busy, key_valid, flag_address_sent}, 3'b010);
    rd(4'd7, v);
    chk("spur_idle_rk7", v, exp[7]);
    run(K3, 2, 0);
    done_pulse();
    spur = 0;
    rd(4'd10, v);
    chk("spur_rk10", v, 128'h13111d7fe3944a17f307a78b4d2b30c5);
    rd(4'd5, v);
    chk("spur_rk5", v, exp[5]);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: total=%0d bad=%0d", total, bad);
    $fatal(1);
  end
endmodule
